// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module   : mem_stage
// Brief    : RV64 memory stage - ALU passthrough, single-outstanding load/store.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int XLEN        = 64,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rd,
  input  logic [4:0]      in_rd_addr,
  input  logic            in_rd_w,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [2:0]      in_func3,
  input  logic [XLEN-1:0] in_store_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_rd,
  output logic [4:0]      wb_rd_addr,
  output logic            wb_rd_w,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_is_store;
  logic [2:0]      w_off;
  logic [1:0]      w_size;
  logic            w_misalign;
  logic            w_go_mem;
  logic [7:0]      w_strb_base;
  logic [XLEN-1:0] w_rsp_shift;
  logic [XLEN-1:0] w_load_data;

  logic [2:0]      r_off;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [4:0]      r_rd_addr;
  logic            r_rd_w;

  assign in_ready      = (r_state == S_IDLE);
  assign mem_req_valid = (r_state == S_REQ);

  assign w_accept   = in_valid & in_ready;
  assign w_is_mem   = in_load | in_store;
  // A load wins when both load and store are flagged.
  assign w_is_store = in_store & ~in_load;
  assign w_off      = in_rd[2:0];
  assign w_size     = in_func3[1:0];
  assign w_go_mem   = w_accept & w_is_mem & ~w_misalign;

  always_comb begin
    w_misalign  = 1'b0;
    w_strb_base = 8'h01;
    case (w_size)
      2'b00: w_strb_base = 8'h01;
      2'b01: begin
        w_strb_base = 8'h03;
        w_misalign  = w_off[0];
      end
      2'b10: begin
        w_strb_base = 8'h0F;
        w_misalign  = |w_off[1:0];
      end
      default: begin
        w_strb_base = 8'hFF;
        w_misalign  = |w_off;
      end
    endcase
    if (!ALIGN_CHECK) w_misalign = 1'b0;
  end

  // Load data is realigned to bit 0 and then extended from the access size.
  assign w_rsp_shift = mem_rsp_data >> {r_off, 3'b000};

  always_comb begin
    w_load_data = w_rsp_shift;
    case (r_size)
      2'b00:   w_load_data = {{(XLEN-8){~r_unsigned & w_rsp_shift[7]}},   w_rsp_shift[7:0]};
      2'b01:   w_load_data = {{(XLEN-16){~r_unsigned & w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      2'b10:   w_load_data = {{(XLEN-32){~r_unsigned & w_rsp_shift[31]}}, w_rsp_shift[31:0]};
      default: w_load_data = w_rsp_shift;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go_mem)      w_state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_rsp_valid) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_rd_addr    <= 5'd0;
      wb_rd_w       <= 1'b0;
      misalign      <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= 8'h00;
      r_off         <= 3'd0;
      r_size        <= 2'd0;
      r_unsigned    <= 1'b0;
      r_rd_addr     <= 5'd0;
      r_rd_w        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_is_mem) begin
              wb_valid   <= 1'b1;
              wb_rd      <= in_rd;
              wb_rd_addr <= in_rd_addr;
              wb_rd_w    <= in_rd_w & (|in_rd_addr);
            end else if (w_misalign) begin
              wb_valid   <= 1'b1;
              misalign   <= 1'b1;
              wb_rd_addr <= in_rd_addr;
              wb_rd_w    <= 1'b0;
            end else begin
              mem_req_addr  <= {in_rd[XLEN-1:3], 3'b000};
              mem_req_we    <= w_is_store;
              mem_req_wstrb <= w_is_store ? (w_strb_base << w_off) : 8'h00;
              mem_req_wdata <= w_is_store ? (in_store_data << {w_off, 3'b000}) : '0;
              r_off         <= w_off;
              r_size        <= w_size;
              r_unsigned    <= in_func3[2];
              r_rd_addr     <= in_rd_addr;
              r_rd_w        <= in_rd_w;
            end
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            wb_valid   <= 1'b1;
            wb_rd_addr <= r_rd_addr;
            if (mem_req_we) begin
              wb_rd_w <= 1'b0;
            end else begin
              wb_rd   <= w_load_data;
              wb_rd_w <= r_rd_w & (|r_rd_addr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
